// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory (req/gnt/rvalid), buffers returned words in a small
// first-word-fall-through FIFO and presents {instr, pc} to the IF-ID register.
// Redirects from later stages flush the FIFO and restart fetch at the new PC.
// Optional feature: define MILANO_FETCH_ALIGN_CHK_EN to flag misaligned
// redirect targets on fetch_err_o and halt fetching until an aligned redirect.
module instr_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;
    logic [31:0]      r_req_pc;
    logic [31:0]      w_req_pc_nxt;
    logic             r_discard;
    logic             w_discard_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic             r_req;
    logic [31:0]      r_addr;
    logic             r_valid;
    logic [31:0]      r_fifo_instr [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc    [FIFO_DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_go;
    logic             w_redir_mis;
    logic [31:0]      w_redir_pc;

    // Handshake decode: what enters and leaves the FIFO this cycle
    always_comb begin
        w_redir_pc = redirect_pc_i & 32'hFFFF_FFFC;
`ifdef MILANO_FETCH_ALIGN_CHK_EN
        w_redir_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
        w_redir_mis = 1'b0;
`endif
        // A redirect flushes the FIFO, so neither a pop nor the returning word counts
        w_pop  = r_valid && instr_ready_i && !redirect_i;
        w_push = (r_state == S_WAIT) && instr_rvalid_i && !r_discard && !redirect_i;
    end

    // Next-state logic: fetch FSM, PC, discard/error flags and FIFO occupancy
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_discard_nxt  = r_discard;
        w_err_nxt      = r_err;
        w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_wptr_nxt     = r_wptr + PTR_W'(w_push);
        w_rptr_nxt     = r_rptr + PTR_W'(w_pop);
        w_go           = fetch_en_i && !r_err && (w_count_nxt != CNT_W'(FIFO_DEPTH));

        if (redirect_i) begin
            w_count_nxt    = '0;
            w_wptr_nxt     = '0;
            w_rptr_nxt     = '0;
            w_fetch_pc_nxt = w_redir_pc;
            w_err_nxt      = w_redir_mis;
            w_go           = fetch_en_i && !w_redir_mis;
            w_discard_nxt  = 1'b0;
            case (r_state)
                S_REQ: begin
                    // Granted this cycle: data is still owed, so wait and drop it
                    if (instr_gnt_i) begin
                        w_discard_nxt = 1'b1;
                        w_state_nxt   = S_WAIT;
                    end else begin
                        w_state_nxt = w_go ? S_REQ : S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Returning word completes the stale request right here
                    if (instr_rvalid_i) begin
                        w_state_nxt = w_go ? S_REQ : S_IDLE;
                    end else begin
                        w_discard_nxt = 1'b1;
                        w_state_nxt   = S_WAIT;
                    end
                end
                default: w_state_nxt = w_go ? S_REQ : S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (instr_gnt_i) begin
                        w_req_pc_nxt   = r_fetch_pc;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                        w_state_nxt    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (instr_rvalid_i) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = w_go ? S_REQ : S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and control registers, including registered memory-side and IF-ID outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= BOOT_ADDR;
            r_req_pc   <= '0;
            r_discard  <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_err      <= w_err_nxt;
            r_count    <= w_count_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_req      <= (w_state_nxt == S_REQ);
            r_addr     <= (w_state_nxt == S_REQ) ? w_fetch_pc_nxt : 32'd0;
            r_valid    <= (w_count_nxt != '0);
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_instr[PTR_W'(i)] <= '0;
                r_fifo_pc[PTR_W'(i)]    <= '0;
            end
        end else if (w_push) begin
            r_fifo_instr[r_wptr] <= instr_rdata_i;
            r_fifo_pc[r_wptr]    <= r_req_pc;
        end
    end

    assign instr_req_o   = r_req;
    assign instr_addr_o  = r_addr;
    assign instr_valid_o = r_valid;
    assign instr_rdata_o = r_fifo_instr[r_rptr];
    assign instr_pc_o    = r_fifo_pc[r_rptr];
    assign fetch_err_o   = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder, a program-order reference model
// (request address stream and delivered {pc, instr} stream) checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_instr_fetch;

    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_en_i = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        fetch_err_o;

    logic        gnt_allow = 1'b1;
    int          rv_lat = 1;
    int          checks = 0;
    int          errors = 0;

    instr_fetch dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .fetch_en_i    (fetch_en_i),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .fetch_err_o   (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    assign instr_gnt_i = instr_req_o & gnt_allow;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: returns the granted word rv_lat cycles after the grant
    logic        hs_seen = 1'b0;
    logic [31:0] hs_addr = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;

    always @(negedge clk_i) begin
        hs_seen = rst_ni && instr_req_o && instr_gnt_i;
        hs_addr = instr_addr_o;
    end

    always @(posedge clk_i) begin
        #1;
        instr_rvalid_i = 1'b0;
        if (hs_seen) begin
            pend      = 1'b1;
            pend_addr = hs_addr;
            pend_wait = rv_lat;
            hs_seen   = 1'b0;
        end
        if (pend) begin
            pend_wait--;
            if (pend_wait <= 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(pend_addr);
                pend           = 1'b0;
            end
        end
    end

    // Reference model: requests and delivered words follow program order from the
    // last redirect target (or BOOT), with at most one request outstanding
    logic [31:0] m_req_addr = BOOT;
    logic [31:0] m_pop_pc = BOOT;
    int          m_out = 0;
    logic        m_err = 1'b0;
    logic        p_req = 1'b0;
    logic        p_gnt = 1'b0;
    logic        p_red = 1'b0;
    logic [31:0] p_addr = '0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_req_addr = BOOT;
            m_pop_pc   = BOOT;
            m_out      = 0;
            m_err      = 1'b0;
            p_req      = 1'b0;
            p_gnt      = 1'b0;
            p_red      = 1'b0;
            p_addr     = '0;
        end else begin
            chk("fetch_err", 32'(fetch_err_o), 32'(m_err));
            if (p_red) chk("flush_valid", 32'(instr_valid_o), 32'd0);
            if (m_err) chk("err_no_req", 32'(instr_req_o), 32'd0);
            if (p_req && !p_gnt && !p_red) begin
                chk("req_held", 32'(instr_req_o), 32'd1);
                chk("addr_held", instr_addr_o, p_addr);
            end
            if (instr_req_o) chk("single_outstanding", 32'(m_out), 32'd0);
            if (instr_req_o && instr_gnt_i) chk("req_addr", instr_addr_o, m_req_addr);
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                chk("pop_pc", instr_pc_o, m_pop_pc);
                chk("pop_instr", instr_rdata_o, mem_word(m_pop_pc));
            end

            if (instr_req_o && instr_gnt_i) begin
                m_req_addr = m_req_addr + 32'd4;
                m_out++;
            end
            if (instr_rvalid_i && m_out > 0) m_out--;
            if (instr_valid_o && instr_ready_i && !redirect_i) m_pop_pc = m_pop_pc + 32'd4;
            if (redirect_i) begin
                m_req_addr = redirect_pc_i & 32'hFFFF_FFFC;
                m_pop_pc   = redirect_pc_i & 32'hFFFF_FFFC;
`ifdef MILANO_FETCH_ALIGN_CHK_EN
                m_err = (redirect_pc_i[1:0] != 2'b00);
`endif
            end
            p_red  = redirect_i;
            p_req  = instr_req_o;
            p_gnt  = instr_gnt_i;
            p_addr = instr_addr_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Assert reset, confirm all outputs are zero, release; returns just after release
    task automatic do_reset();
        tick();
        rst_ni        = 1'b0;
        fetch_en_i    = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        gnt_allow     = 1'b1;
        rv_lat        = 1;
        @(negedge clk_i);
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_addr", instr_addr_o, 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_rdata", instr_rdata_o, 32'd0);
        chk("rst_pc", instr_pc_o, 32'd0);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic wait_hs(input logic [31:0] a, input string nm);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk_i);
            if (instr_req_o && instr_gnt_i && instr_addr_o == a) found = 1'b1;
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk_i);
            if (instr_valid_o) found = 1'b1;
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    logic [31:0] hs_q [4];
    int          n_hs;
    int          first_valid;
    int          n_req;

    initial begin
        // Streaming fetch: grants at once, data one cycle later
        do_reset();
        fetch_en_i    = 1'b1;
        instr_ready_i = 1'b1;
        first_valid   = -1;
        n_hs          = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (instr_valid_o && first_valid < 0) first_valid = c;
            if (instr_req_o && instr_gnt_i) begin
                if (n_hs < 4) hs_q[n_hs] = instr_addr_o;
                n_hs++;
            end
        end
        chk("t1_first_valid", 32'(first_valid), 32'd3);
        chk("t1_addr0", hs_q[0], 32'h80);
        chk("t1_addr1", hs_q[1], 32'h84);
        chk("t1_addr2", hs_q[2], 32'h88);
        chk("t1_hs_count", 32'(n_hs), 32'd5);

        // Backpressure: FIFO fills with two words, then requests stop
        do_reset();
        fetch_en_i = 1'b1;
        n_hs  = 0;
        n_req = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (instr_req_o && instr_gnt_i) n_hs++;
            if (c >= 6 && instr_req_o) n_req++;
        end
        chk("t2_hs_count", 32'(n_hs), 32'd2);
        chk("t2_req_idle", 32'(n_req), 32'd0);
        chk("t2_valid", 32'(instr_valid_o), 32'd1);
        tick();
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        chk("t2_head0", instr_pc_o, 32'h80);
        @(negedge clk_i);
        chk("t2_head1", instr_pc_o, 32'h84);
        chk("t2_head1_valid", 32'(instr_valid_o), 32'd1);
        for (int c = 0; c < 8; c++) @(negedge clk_i);

        // Grant withheld: request and address stay stable, exactly one request issued
        do_reset();
        gnt_allow     = 1'b0;
        fetch_en_i    = 1'b1;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            chk("t3_req_hold", 32'(instr_req_o), 32'd1);
            chk("t3_addr_hold", instr_addr_o, 32'h80);
        end
        tick();
        gnt_allow = 1'b1;
        n_hs = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            if (instr_req_o && instr_gnt_i) n_hs++;
        end
        chk("t3_one_req", 32'(n_hs), 32'd1);
        for (int c = 0; c < 6; c++) @(negedge clk_i);

        // Redirect while waiting for 0x84: that word is dropped, stream resumes at 0x200
        do_reset();
        fetch_en_i    = 1'b1;
        instr_ready_i = 1'b1;
        rv_lat        = 2;
        wait_hs(32'h84, "t4_hs84");
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        @(negedge clk_i);
        chk("t4_rvalid_late", 32'(instr_rvalid_i), 32'd0);
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("t4_empty", 32'(instr_valid_o), 32'd0);
        wait_valid("t4_valid_seen");
        chk("t4_pc", instr_pc_o, 32'h200);
        chk("t4_instr", instr_rdata_o, mem_word(32'h200));
        for (int c = 0; c < 4; c++) @(negedge clk_i);

        // Redirect coinciding with push and pop: FIFO empties, next request at target
        do_reset();
        fetch_en_i = 1'b1;
        rv_lat     = 1;
        wait_hs(32'h84, "t5_hs84");
        tick();
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        @(negedge clk_i);
        chk("t5_setup_valid", 32'(instr_valid_o), 32'd1);
        chk("t5_setup_rvalid", 32'(instr_rvalid_i), 32'd1);
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("t5_empty", 32'(instr_valid_o), 32'd0);
        chk("t5_req", 32'(instr_req_o), 32'd1);
        chk("t5_addr", instr_addr_o, 32'h300);
        for (int c = 0; c < 6; c++) @(negedge clk_i);

        // Misaligned redirect target
        do_reset();
        fetch_en_i    = 1'b1;
        instr_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge clk_i);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h202;
        tick();
        redirect_i = 1'b0;
`ifdef MILANO_FETCH_ALIGN_CHK_EN
        n_req = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (instr_req_o) n_req++;
        end
        chk("t6_err_set", 32'(fetch_err_o), 32'd1);
        chk("t6_no_req", 32'(n_req), 32'd0);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("t6_err_clr", 32'(fetch_err_o), 32'd0);
        wait_hs(32'h300, "t6_resume_300");
`else
        wait_hs(32'h200, "t6_resume_200");
        chk("t6_err_zero", 32'(fetch_err_o), 32'd0);
`endif
        for (int c = 0; c < 6; c++) @(negedge clk_i);

        // PC wraps from the top of the address space to zero
        do_reset();
        fetch_en_i    = 1'b1;
        instr_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge clk_i);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        wait_hs(32'hFFFF_FFFC, "t7_wrap_hi");
        wait_hs(32'h0000_0000, "t7_wrap_lo");
        for (int c = 0; c < 6; c++) @(negedge clk_i);

        // Reset mid-request: the stale data beat after release is ignored
        do_reset();
        fetch_en_i    = 1'b1;
        instr_ready_i = 1'b1;
        rv_lat        = 3;
        wait_hs(32'h80, "t8_hs80");
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni    = 1'b1;
        gnt_allow = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t8_stale_rvalid", 32'(instr_rvalid_i), 32'd1);
        chk("t8_req", 32'(instr_req_o), 32'd1);
        chk("t8_addr", instr_addr_o, 32'h80);
        tick();
        gnt_allow = 1'b1;
        wait_valid("t8_valid_seen");
        chk("t8_pc", instr_pc_o, 32'h80);
        chk("t8_instr", instr_rdata_o, mem_word(32'h80));
        for (int c = 0; c < 4; c++) @(negedge clk_i);

        // fetch_en_i dropped with a request in flight: the word still lands, no new request
        do_reset();
        fetch_en_i = 1'b1;
        rv_lat     = 1;
        wait_hs(32'h80, "t9_hs80");
        tick();
        fetch_en_i = 1'b0;
        n_req = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (instr_req_o) n_req++;
        end
        chk("t9_no_req", 32'(n_req), 32'd0);
        chk("t9_valid", 32'(instr_valid_o), 32'd1);
        chk("t9_pc", instr_pc_o, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
